// File: rtl/blackbox_vector_checker.sv
// Vector-table checker: replays stored stimuli into an external block and compares
// each response against a stored expectation after a programmable latency.
//
// state | meaning
// IDLE  | waiting for start, table writable
// DRIVE | present stim[idx] on dut_in, load latency timer
// WAIT  | latency timer counting down to the sample point
// CHECK | compare dut_out with exp[idx], advance or finish
// DONE  | run complete, results held until the next start

module blackbox_vector_checker #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    parameter  int LAT_W = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_stim,
    input  logic [WIDTH-1:0] wr_exp,
    input  logic [AW:0]      num_vec,
    input  logic [LAT_W-1:0] latency,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [AW-1:0]    first_err_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT state;
    stateT stateNext;

    logic [WIDTH-1:0] stimMem [DEPTH];
    logic [WIDTH-1:0] expMem  [DEPTH];

    logic [AW:0]      numVecReg;
    logic [LAT_W-1:0] latReg;
    logic [LAT_W-1:0] waitCnt;
    logic [AW-1:0]    idx;

    logic       loadRun;
    logic       driveStep;
    logic       waitStep;
    logic       checkStep;
    logic       enterDone;
    logic       lastVec;
    logic       mismatch;
    logic [7:0] errSat;
    logic [7:0] errFinal;

    assign busy     = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    assign lastVec  = ({1'b0, idx} == (numVecReg - (AW+1)'(1)));
    assign mismatch = (dut_out != expMem[idx]);
    assign errSat   = (err_count == 8'hFF) ? err_count : (err_count + 8'd1);

    // Table storage has no reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en && !busy) begin
            stimMem[wr_addr] <= wr_stim;
            expMem[wr_addr]  <= wr_exp;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadRun   = 1'b0;
        driveStep = 1'b0;
        waitStep  = 1'b0;
        checkStep = 1'b0;
        enterDone = 1'b0;
        errFinal  = err_count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    loadRun  = 1'b1;
                    errFinal = '0;
                    if (num_vec == '0) begin
                        stateNext = DONE;
                        enterDone = 1'b1;
                    end else begin
                        stateNext = DRIVE;
                    end
                end
            end
            DRIVE: begin
                driveStep = 1'b1;
                stateNext = (latReg != '0) ? WAIT : CHECK;
            end
            WAIT: begin
                waitStep = 1'b1;
                if (waitCnt <= LAT_W'(1)) begin
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                checkStep = 1'b1;
                if (mismatch) begin
                    errFinal = errSat;
                end
                if (lastVec) begin
                    stateNext = DONE;
                    enterDone = 1'b1;
                end else begin
                    stateNext = DRIVE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dut_in        <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            numVecReg     <= '0;
            latReg        <= '0;
            waitCnt       <= '0;
            idx           <= '0;
        end else begin
            done <= enterDone;
            if (loadRun) begin
                numVecReg     <= num_vec;
                latReg        <= latency;
                idx           <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                pass          <= 1'b0;
            end
            if (driveStep) begin
                dut_in  <= stimMem[idx];
                waitCnt <= latReg;
            end
            if (waitStep) begin
                waitCnt <= waitCnt - LAT_W'(1);
            end
            if (checkStep) begin
                if (mismatch) begin
                    err_count <= errSat;
                    if (err_count == 8'd0) begin
                        first_err_idx <= idx;
                    end
                end
                if (!lastVec) begin
                    idx <= idx + AW'(1);
                end
            end
            // An empty run reaches DONE in the same edge as loadRun, so this must win.
            if (enterDone) begin
                pass <= (errFinal == 8'd0);
            end
        end
    end

endmodule
